// File: rtl/fg_prog_sequencer.sv
// Programming-mux sequencer for one floating-gate island.
// Takes one inject/tunnel/read command at a time over valid/ready, walks
// SETUP -> (PULSE/GAP | MEAS) -> HOLD -> DONE, and drives the row/column
// decoders, drain select, program-switch enable and pulse lines.
// Every output is a flop loaded from the next-state decode. Each output
// therefore changes on the same edge as the state it belongs to.
module fg_prog_sequencer #(
  parameter int ROW_AW    = 2,
  parameter int COL_AW    = 3,
  parameter int CNT_W     = 8,
  parameter int PW_W      = 16,
  parameter int SETUP_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int HOLD_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ROW_AW-1:0]       cmd_row,
  input  logic [COL_AW-1:0]       cmd_col,
  input  logic [1:0]              cmd_mode,
  input  logic [CNT_W-1:0]        cmd_pulses,
  input  logic [PW_W-1:0]         cmd_width,
  input  logic                    abort,
  output logic [ROW_AW-1:0]       dec_row_addr,
  output logic                    dec_row_en,
  output logic [COL_AW-1:0]       dec_col_addr,
  output logic                    dec_col_en,
  output logic [(2**ROW_AW)-1:0]  drain_sel,
  output logic                    prog_sw_en,
  output logic                    vinj_pulse,
  output logic                    tun_pulse,
  output logic                    meas_strobe,
  output logic                    done_valid,
  output logic                    done_err
);

  localparam int NUM_ROWS = 2**ROW_AW;

  localparam logic [1:0] MODE_INJ  = 2'b00;
  localparam logic [1:0] MODE_TUN  = 2'b01;
  localparam logic [1:0] MODE_READ = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  // Every phase length is counted down in one PW_W-wide counter.
  localparam logic [PW_W-1:0]     ONE_PW    = PW_W'(1);
  localparam logic [PW_W-1:0]     SETUP_LEN = PW_W'(SETUP_CYC);
  localparam logic [PW_W-1:0]     GAP_LEN   = PW_W'(GAP_CYC);
  localparam logic [PW_W-1:0]     HOLD_LEN  = PW_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]    ONE_CNT   = CNT_W'(1);
  localparam logic [NUM_ROWS-1:0] ROW0_HOT  = {{(NUM_ROWS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_MEAS,
    S_HOLD,
    S_DONE
  } state_t;

  // Current state, phase countdown, pulses left, and the latched command.
  state_t             r_state;
  logic [PW_W-1:0]    r_cnt;
  logic [CNT_W-1:0]   r_left;
  logic [ROW_AW-1:0]  r_row;
  logic [COL_AW-1:0]  r_col;
  logic [1:0]         r_mode;
  logic [PW_W-1:0]    r_width;
  logic               r_err;

  state_t             w_state_nxt;
  logic [PW_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]   w_left_nxt;
  logic [ROW_AW-1:0]  w_row_nxt;
  logic [COL_AW-1:0]  w_col_nxt;
  logic [1:0]         w_mode_nxt;
  logic [PW_W-1:0]    w_width_nxt;
  logic               w_err_nxt;
  logic               w_accept;
  logic [PW_W-1:0]    w_width_eff;
  logic               w_active_nxt;
  logic               w_abortable;

  // Next-state, phase counters and command latch.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - ONE_PW;
    w_left_nxt  = r_left;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_mode_nxt  = r_mode;
    w_width_nxt = r_width;
    w_err_nxt   = r_err;

    w_accept    = (r_state == S_IDLE) && cmd_valid && cmd_ready;
    w_width_eff = (r_width == '0) ? ONE_PW : r_width;
    w_abortable = abort && ((r_state == S_SETUP) || (r_state == S_PULSE) ||
                            (r_state == S_GAP)   || (r_state == S_MEAS));

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (w_accept) begin
          w_row_nxt   = cmd_row;
          w_col_nxt   = cmd_col;
          w_mode_nxt  = cmd_mode;
          w_width_nxt = cmd_width;
          w_left_nxt  = cmd_pulses;
          if (cmd_mode == MODE_ILL) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = SETUP_LEN;
            w_err_nxt   = 1'b0;
          end
        end
      end

      S_SETUP: begin
        if (r_cnt == ONE_PW) begin
          if (r_mode == MODE_READ) begin
            w_state_nxt = S_MEAS;
          end else if (r_left == '0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LEN;
          end else begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = w_width_eff;
          end
        end
      end

      S_PULSE: begin
        if (r_cnt == ONE_PW) begin
          w_left_nxt = r_left - ONE_CNT;
          if (r_left == ONE_CNT) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LEN;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LEN;
          end
        end
      end

      S_GAP: begin
        if (r_cnt == ONE_PW) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = w_width_eff;
        end
      end

      S_MEAS: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = HOLD_LEN;
      end

      S_HOLD: begin
        if (r_cnt == ONE_PW) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides any phase progress: straight to a full HOLD, flagged.
    if (w_abortable) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = HOLD_LEN;
      w_err_nxt   = 1'b1;
    end

    w_active_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                   (w_state_nxt == S_GAP)   || (w_state_nxt == S_MEAS)  ||
                   (w_state_nxt == S_HOLD);
  end

  // State, counters and registered outputs, all loaded from the next-state decode.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_left       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_mode       <= MODE_INJ;
      r_width      <= '0;
      r_err        <= 1'b0;
      cmd_ready    <= 1'b0;
      dec_row_addr <= '0;
      dec_row_en   <= 1'b0;
      dec_col_addr <= '0;
      dec_col_en   <= 1'b0;
      drain_sel    <= '0;
      prog_sw_en   <= 1'b0;
      vinj_pulse   <= 1'b0;
      tun_pulse    <= 1'b0;
      meas_strobe  <= 1'b0;
      done_valid   <= 1'b0;
      done_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_left       <= w_left_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_mode       <= w_mode_nxt;
      r_width      <= w_width_nxt;
      r_err        <= w_err_nxt;
      cmd_ready    <= (w_state_nxt == S_IDLE);
      dec_row_addr <= w_active_nxt ? w_row_nxt : '0;
      dec_row_en   <= w_active_nxt;
      dec_col_addr <= w_active_nxt ? w_col_nxt : '0;
      dec_col_en   <= w_active_nxt;
      // Tunnelling does not use the drain; inject and read ground the target row.
      drain_sel    <= (w_active_nxt && (w_mode_nxt != MODE_TUN)) ? (ROW0_HOT << w_row_nxt) : '0;
      prog_sw_en   <= w_active_nxt;
      vinj_pulse   <= (w_state_nxt == S_PULSE) && (w_mode_nxt == MODE_INJ);
      tun_pulse    <= (w_state_nxt == S_PULSE) && (w_mode_nxt == MODE_TUN);
      meas_strobe  <= (w_state_nxt == S_MEAS);
      done_valid   <= (w_state_nxt == S_DONE);
      done_err     <= (w_state_nxt == S_DONE) && w_err_nxt;
    end
  end

endmodule
